// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared types and constants for the pulse burst sequencer
//
// Holds the sequencer FSM state encoding and the pulse width value that
// causes a start command to be rejected.
package pulse_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DELAY = 3'd1,
      ST_FIRE  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_e;

   // A start carrying this pulse width is refused with an err strobe.
   localparam int unsigned PW_REJECT = 0;

endpackage

// File: rtl/seq_down_cnt.sv
// rtl/seq_down_cnt.sv - loadable saturating down counter with zero flag
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   load_i         load val_i (has priority over en_i)
//   en_i           decrement by one, holding at zero
//   val_i          load value
//   zero_o         counter currently reads zero
module seq_down_cnt
   import pulse_seq_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_burst_seq.sv
// rtl/pulse_burst_seq.sv - burst trigger sequencer feeding the single-pulse generator
//
// After io_start it waits io_trigDelay cycles, then issues io_en strobes whose
// spacing is max(period, pulse width + 1): each strobe waits for both the
// period counter and the generator's end-of-pulse flag.
// Optional end-of-pulse watchdog: define SEQ_WATCHDOG_EN.
//
// Ports:
//   io_clk, io_rst_n     clock, asynchronous active-low reset
//   io_start, io_abort   one-cycle commands (abort wins)
//   io_trigDelay, io_pulseWidth, io_period, io_burstCnt
//                        configuration, sampled on the accepted start cycle only
//   io_pulseValid        end-of-pulse flag from the generator
//   io_en                one-cycle pulse-start strobe (generator load-enable)
//   io_pulseWidthOut     width latched at start
//   pwm_dis              one-cycle generator disable on abort / watchdog
//   busy                 sequence active (DELAY, FIRE, WAIT)
//   done, err            one-cycle status strobes
//   pulse_idx            pulses issued in the current burst
module pulse_burst_seq
   import pulse_seq_pkg::*;
#(
   parameter int unsigned _RAM_WIDTH = 32,
   parameter int unsigned CNT_W      = 16
`ifdef SEQ_WATCHDOG_EN
   ,
   parameter int unsigned WD_MARGIN  = 16
`endif
) (
   input  logic                  io_clk,
   input  logic                  io_rst_n,
   input  logic                  io_start,
   input  logic                  io_abort,
   input  logic [_RAM_WIDTH-1:0] io_trigDelay,
   input  logic [_RAM_WIDTH-1:0] io_pulseWidth,
   input  logic [_RAM_WIDTH-1:0] io_period,
   input  logic [CNT_W-1:0]      io_burstCnt,
   input  logic                  io_pulseValid,
   output logic                  io_en,
   output logic [_RAM_WIDTH-1:0] io_pulseWidthOut,
   output logic                  pwm_dis,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CNT_W-1:0]      pulse_idx
);

   seq_state_e state_q, state_d;

   logic                  en_q, en_d;
   logic                  dis_q, dis_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      idx_q, idx_d;
   logic [_RAM_WIDTH-1:0] pw_q, pw_d;
   logic [_RAM_WIDTH-1:0] period_q, period_d;
   logic [CNT_W-1:0]      burst_q, burst_d;
   logic                  flag_q, flag_d;

   logic                  dly_load;
   logic                  dly_zero;
   logic [_RAM_WIDTH-1:0] dly_val;

   logic                  fire_entry;
   logic                  cnt_run;
   logic [_RAM_WIDTH-1:0] per_src;
   logic [_RAM_WIDTH-1:0] per_val;
   logic                  per_zero;

   // Counters are loaded on the edge that enters FIRE, so the period counter
   // already reads period-1 during the strobe cycle; this makes the strobe
   // spacing exactly the period rather than period+1.
   assign fire_entry = (state_d == ST_FIRE);
   assign cnt_run    = (state_q == ST_FIRE) || (state_q == ST_WAIT);

   // From IDLE the configuration is being latched on this same edge, so the
   // raw inputs are the source; afterwards the latched copies are used.
   assign per_src = (state_q == ST_IDLE) ? io_period : period_q;
   assign per_val = (per_src == '0) ? '0 : (per_src - _RAM_WIDTH'(1));
   assign dly_val = io_trigDelay - _RAM_WIDTH'(1);

   seq_down_cnt #(.W(_RAM_WIDTH)) u_dly_cnt (
      .clk_i  (io_clk),
      .rst_ni (io_rst_n),
      .load_i (dly_load),
      .en_i   (state_q == ST_DELAY),
      .val_i  (dly_val),
      .zero_o (dly_zero)
   );

   seq_down_cnt #(.W(_RAM_WIDTH)) u_per_cnt (
      .clk_i  (io_clk),
      .rst_ni (io_rst_n),
      .load_i (fire_entry),
      .en_i   (cnt_run),
      .val_i  (per_val),
      .zero_o (per_zero)
   );

`ifdef SEQ_WATCHDOG_EN
   localparam int unsigned WDW = _RAM_WIDTH + 1;

   logic [_RAM_WIDTH-1:0] pw_src;
   logic [WDW-1:0]        wd_sum;
   logic [_RAM_WIDTH-1:0] wd_val;
   logic                  wd_zero;

   // Loaded with width+margin-1 on FIRE entry: it reaches zero on the cycle
   // width+margin-1 after the strobe, so the trip strobes land exactly
   // width+margin cycles after io_en. Saturates instead of wrapping.
   assign pw_src = (state_q == ST_IDLE) ? io_pulseWidth : pw_q;
   assign wd_sum = {1'b0, pw_src} + WDW'(WD_MARGIN) - WDW'(1);
   assign wd_val = wd_sum[_RAM_WIDTH] ? '1 : wd_sum[_RAM_WIDTH-1:0];

   seq_down_cnt #(.W(_RAM_WIDTH)) u_wd_cnt (
      .clk_i  (io_clk),
      .rst_ni (io_rst_n),
      .load_i (fire_entry),
      .en_i   (cnt_run),
      .val_i  (wd_val),
      .zero_o (wd_zero)
   );
`endif

   always_comb begin
      state_d  = state_q;
      en_d     = 1'b0;
      dis_d    = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      idx_d    = idx_q;
      pw_d     = pw_q;
      period_d = period_q;
      burst_d  = burst_q;
      flag_d   = flag_q;
      dly_load = 1'b0;

      if ((state_q != ST_IDLE) && io_abort) begin
         state_d = ST_IDLE;
         dis_d   = 1'b1;
         done_d  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (io_start && !io_abort) begin
                  if (io_pulseWidth == _RAM_WIDTH'(PW_REJECT)) begin
                     err_d = 1'b1;
                  end else begin
                     pw_d     = io_pulseWidth;
                     period_d = io_period;
                     burst_d  = io_burstCnt;
                     idx_d    = '0;
                     if (io_trigDelay == '0) begin
                        state_d = ST_FIRE;
                     end else begin
                        state_d  = ST_DELAY;
                        dly_load = 1'b1;
                     end
                  end
               end
            end
            ST_DELAY: begin
               if (dly_zero) begin
                  state_d = ST_FIRE;
               end
            end
            ST_FIRE: begin
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (io_pulseValid) begin
                  flag_d = 1'b1;
               end
`ifdef SEQ_WATCHDOG_EN
               if (wd_zero && !flag_q && !io_pulseValid) begin
                  state_d = ST_IDLE;
                  dis_d   = 1'b1;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
               end else
`endif
               if (per_zero && (flag_q || io_pulseValid)) begin
                  if ((burst_q != '0) && (idx_q == burst_q)) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_FIRE;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Strobe outputs are registered, so they are decided from the next state.
      if (state_d == ST_FIRE) begin
         en_d   = 1'b1;
         idx_d  = idx_d + CNT_W'(1);
         flag_d = 1'b0;
      end
      if (state_d == ST_DONE) begin
         done_d = 1'b1;
      end
      busy_d = (state_d == ST_DELAY) || (state_d == ST_FIRE) || (state_d == ST_WAIT);
   end

   always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
         state_q  <= ST_IDLE;
         en_q     <= 1'b0;
         dis_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         pw_q     <= '0;
         period_q <= '0;
         burst_q  <= '0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         dis_q    <= dis_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
         pw_q     <= pw_d;
         period_q <= period_d;
         burst_q  <= burst_d;
         flag_q   <= flag_d;
      end
   end

   assign io_en            = en_q;
   assign io_pulseWidthOut = pw_q;
   assign pwm_dis          = dis_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;
   assign pulse_idx        = idx_q;

endmodule

// File: tb/tb_pulse_burst_seq.sv
// tb/tb_pulse_burst_seq.sv - scoreboard testbench for pulse_burst_seq
module tb_pulse_burst_seq;

   localparam int K_EN   = 0;
   localparam int K_DIS  = 1;
   localparam int K_ERR  = 2;
   localparam int K_DONE = 3;

   typedef struct {
      int kind;
      int cyc;
      int idx;
   } ev_t;

   logic        clk = 1'b0;
   logic        io_rst_n = 1'b0;
   logic        io_start = 1'b0;
   logic        io_abort = 1'b0;
   logic [31:0] io_trigDelay = '0;
   logic [31:0] io_pulseWidth = '0;
   logic [31:0] io_period = '0;
   logic [15:0] io_burstCnt = '0;
   logic        io_pulseValid = 1'b0;
   logic        io_en;
   logic [31:0] io_pulseWidthOut;
   logic        pwm_dis;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] pulse_idx;

   int  cyc = 0;
   int  n_assert = 0;
   int  n_fail = 0;
   ev_t exp_q[$];
   int  pv_due[$];
   bit  pv_on = 1'b1;
   int  pv_lat = 1;

   always #5 clk = ~clk;

   pulse_burst_seq dut (
      .io_clk           (clk),
      .io_rst_n         (io_rst_n),
      .io_start         (io_start),
      .io_abort         (io_abort),
      .io_trigDelay     (io_trigDelay),
      .io_pulseWidth    (io_pulseWidth),
      .io_period        (io_period),
      .io_burstCnt      (io_burstCnt),
      .io_pulseValid    (io_pulseValid),
      .io_en            (io_en),
      .io_pulseWidthOut (io_pulseWidthOut),
      .pwm_dis          (pwm_dis),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .pulse_idx        (pulse_idx)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input longint got, input longint exp);
      n_assert++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int c, input int idx);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.idx  = idx;
      exp_q.push_back(e);
   endtask

   task automatic take(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk_eq("unexpected_evt", kind, -1);
      end else begin
         e = exp_q.pop_front();
         chk_eq("evt_kind", kind, e.kind);
         chk_eq("evt_cyc", cyc, e.cyc);
         if (e.idx >= 0) chk_eq("evt_idx", pulse_idx, e.idx);
      end
   endtask

   // Output monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (io_rst_n) begin
         if (io_en)   take(K_EN);
         if (pwm_dis) take(K_DIS);
         if (err)     take(K_ERR);
         if (done)    take(K_DONE);
         if (io_en && pv_on) pv_due.push_back(cyc + pv_lat);
      end
   end

   // Downstream generator model: end-of-pulse flag pv_lat cycles after io_en.
   always @(posedge clk) begin
      #1;
      io_pulseValid = 1'b0;
      while (pv_due.size() > 0 && pv_due[0] < cyc) void'(pv_due.pop_front());
      if (pv_due.size() > 0 && pv_due[0] == cyc) begin
         void'(pv_due.pop_front());
         io_pulseValid = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_cyc(input int c);
      while (cyc < c) step();
   endtask

   task automatic drain(input int n);
      repeat (n) step();
      chk_eq("missing_evt", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic start_seq(input int d, input int w, input int p, input int b, output int s);
      io_trigDelay  = d;
      io_pulseWidth = w;
      io_period     = p;
      io_burstCnt   = 16'(b);
      io_start      = 1'b1;
      s             = cyc;
      step();
      io_start      = 1'b0;
   endtask

   initial begin
      int s;
      repeat (3) step();
      io_rst_n = 1'b1;
      step();
      chk_eq("rst_ctl", {io_en, pwm_dis, busy, done, err}, 0);
      chk_eq("rst_idx", pulse_idx, 0);
      chk_eq("rst_pw", io_pulseWidthOut, 0);

      // Single pulse
      pv_on = 1'b1; pv_lat = 4;
      start_seq(3, 4, 10, 1, s);
      push_ev(K_EN, s + 4, 1);
      push_ev(K_DONE, s + 14, 1);
      goto_cyc(s + 6);
      chk_eq("single_busy", busy, 1);
      chk_eq("single_pwout", io_pulseWidthOut, 4);
      drain(20);
      chk_eq("single_idx", pulse_idx, 1);

      // Period-limited burst
      pv_lat = 2;
      start_seq(0, 2, 8, 3, s);
      push_ev(K_EN, s + 1, 1);
      push_ev(K_EN, s + 9, 2);
      push_ev(K_EN, s + 17, 3);
      push_ev(K_DONE, s + 25, 3);
      drain(32);
      chk_eq("burst_idx", pulse_idx, 3);

      // Width-limited burst; config inputs changed after start must be ignored
      pv_lat = 20;
      start_seq(2, 20, 5, 2, s);
      io_pulseWidth = 1; io_period = 1; io_burstCnt = 0; io_trigDelay = 7;
      push_ev(K_EN, s + 3, 1);
      push_ev(K_EN, s + 24, 2);
      push_ev(K_DONE, s + 45, 2);
      goto_cyc(s + 10);
      chk_eq("wl_pwout", io_pulseWidthOut, 20);
      drain(45);

      // Abort during WAIT of a continuous burst
      pv_lat = 3;
      start_seq(1, 3, 6, 0, s);
      push_ev(K_EN, s + 2, 1);
      push_ev(K_EN, s + 8, 2);
      push_ev(K_DIS, s + 12, 2);
      push_ev(K_DONE, s + 12, 2);
      goto_cyc(s + 11);
      io_abort = 1'b1;
      step();
      io_abort = 1'b0;
      chk_eq("abort_busy", busy, 0);
      step();
      chk_eq("abort_idx", pulse_idx, 2);
      drain(10);

      // Start and abort together in IDLE: nothing happens
      io_start = 1'b1; io_abort = 1'b1; io_pulseWidth = 3; io_trigDelay = 0;
      step();
      io_start = 1'b0; io_abort = 1'b0;
      chk_eq("sa_busy", busy, 0);
      drain(8);

      // Zero width start is rejected
      start_seq(2, 0, 5, 1, s);
      push_ev(K_ERR, s + 1, -1);
      chk_eq("zw_busy", busy, 0);
      drain(8);
      chk_eq("zw_busy_after", busy, 0);

      // Downstream never answers
      pv_on = 1'b0;
      pv_due.delete();
      start_seq(0, 4, 2, 1, s);
      push_ev(K_EN, s + 1, 1);
`ifdef SEQ_WATCHDOG_EN
      push_ev(K_DIS, s + 21, 1);
      push_ev(K_ERR, s + 21, 1);
      push_ev(K_DONE, s + 21, 1);
      drain(30);
      chk_eq("wd_busy", busy, 0);
`else
      goto_cyc(s + 30);
      chk_eq("nowd_busy", busy, 1);
      io_abort = 1'b1;
      push_ev(K_DIS, s + 31, 1);
      push_ev(K_DONE, s + 31, 1);
      step();
      io_abort = 1'b0;
      drain(5);
`endif
      pv_on = 1'b1;

      // Asynchronous reset in the middle of DELAY
      pv_lat = 3;
      start_seq(10, 3, 4, 2, s);
      goto_cyc(s + 3);
      chk_eq("dly_busy", busy, 1);
      #2;
      io_rst_n = 1'b0;
      #1;
      chk_eq("arst_ctl", {io_en, pwm_dis, busy, done, err}, 0);
      chk_eq("arst_pw", io_pulseWidthOut, 0);
      chk_eq("arst_idx", pulse_idx, 0);
      repeat (2) step();
      io_rst_n = 1'b1;
      drain(15);
      chk_eq("post_rst_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
